mdu: RTL

Iterative multiply/divide unit for RV32M. It sits beside the ALU in the execute stage and sequences a shared radix-2 shift/add-subtract datapath over multiple cycles. While an operation is in progress it stalls the pipeline, and it returns the result through a start/done handshake. Operands arrive already forwarded from the execute stage, before the pc/imm operand selection.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_sign_fix.sv | 47 ++++
 rtl/mdu.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and sizing for the RV32M iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_XLEN = 32;
  localparam int CNT_W    = $clog2(MDU_XLEN);

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mduop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic signed_a(input mduop_t op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic signed_b(input mduop_t op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude/sign extraction on accept and sign correction plus
// hi/lo or quotient/remainder selection at the end of an operation.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              mduop,
  input  logic [DATA_WIDTH-1:0]   opr_a,
  input  logic [DATA_WIDTH-1:0]   opr_b,
  input  logic [2:0]              op_q,
  input  logic                    sa_q,
  input  logic                    sb_q,
  input  logic [2*DATA_WIDTH-1:0] acc,
  output logic                    sa,
  output logic                    sb,
  output logic [DATA_WIDTH-1:0]   abs_a,
  output logic [DATA_WIDTH-1:0]   abs_b,
  output logic [DATA_WIDTH-1:0]   fix_res
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;

  assign sa    = signed_a(mduop_t'(mduop)) & opr_a[W-1];
  assign sb    = signed_b(mduop_t'(mduop)) & opr_b[W-1];
  assign abs_a = sa ? -opr_a : opr_a;
  assign abs_b = sb ? -opr_b : opr_b;

  // Multiply leaves the full product in acc; divide leaves {rem, quo}.
  assign prod = (sa_q ^ sb_q) ? -acc : acc;
  assign quo  = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
  assign rem  = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    fix_res = prod[2*W-1:W];
    case (mduop_t'(op_q))
      MUL:        fix_res = prod[W-1:0];
      DIV, DIVU:  fix_res = quo;
      REM, REMU:  fix_res = rem;
      default:    fix_res = prod[2*W-1:W];
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Iterative radix-2 multiply/divide unit for RV32M; stalls EX while busy and
// returns its result through a start/done handshake.
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            mduop,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  stall
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  mdu_state_t      state, state_nxt;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]  acc, acc_step;
  logic [W-1:0]    opnd;

  logic            accept, special;
  logic [W-1:0]    special_res;
  logic            sa, sb;
  logic [W-1:0]    abs_a, abs_b, fix_res;
  logic [W:0]      mul_sum;
  logic [W+1:0]    div_diff;

  assign accept = start && (state == IDLE) && !flush && !rst;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign stall  = accept || (state == CALC) || (state == FIX);

  // Divide-by-zero and signed overflow finish without iterating.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (mduop[2]) begin
      if (opr_b == '0) begin
        special     = 1'b1;
        special_res = mduop[1] ? opr_a : '1;
      end else if (!mduop[0] && opr_a == MIN_NEG && opr_b == '1) begin
        special     = 1'b1;
        special_res = mduop[1] ? '0 : opr_a;
      end
    end
  end

  mdu_sign_fix #(.DATA_WIDTH(W)) u_sign_fix (
    .mduop   (mduop),
    .opr_a   (opr_a),
    .opr_b   (opr_b),
    .op_q    (op_q),
    .sa_q    (sa_q),
    .sb_q    (sb_q),
    .acc     (acc),
    .sa      (sa),
    .sb      (sb),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .fix_res (fix_res)
  );

  // Multiply: add opnd into the high half when the low bit is set, shift right.
  // Divide: shift {rem,quo} left, trial-subtract opnd from the 33-bit remainder.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    div_diff = {1'b0, acc[2*W-1:W-1]} - {2'b00, opnd};
    if (op_q[2])
      acc_step = div_diff[W+1] ? {acc[2*W-2:0], 1'b0}
                               : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      result <= '0;
    end else if (accept) begin
      op_q <= mduop;
      sa_q <= sa;
      sb_q <= sb;
      cnt  <= CNT_W'(W - 1);
      if (special) result <= special_res;
      if (mduop[2]) begin
        acc  <= {{W{1'b0}}, abs_a};
        opnd <= abs_b;
      end else begin
        acc  <= {{W{1'b0}}, abs_b};
        opnd <= abs_a;
      end
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !flush) begin
      result <= fix_res;
    end
  end

endmodule
